tx_bit_timer: RTL

- Parametrised successor of the fixed 25-cycle / 3-bit transmit timer.
- Generates bit-period strobes for a serial transmitter whose bit period is a non-integer number of clocks: CYCLES_PER_GROUP clocks carry BITS_PER_GROUP bits.
- Counts strobes into bytes of BITS_PER_BYTE bits and pulses byte_done.
- Provides a stuff-hold input so inserted stuff bits consume a bit period without advancing the bit count. Sits between the TX controller and the encoder/shift register.

---
 rtl/tx_bit_timer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: bit-period strobe generator for a serial transmitter whose
// bit period is a non-integer number of clocks. CYCLES_PER_GROUP clocks
// carry BITS_PER_GROUP bit strobes, placed at phase positions
// floor(k*CYCLES_PER_GROUP/BITS_PER_GROUP)-1 for k = 1..BITS_PER_GROUP.
// Strobes are counted into bytes of BITS_PER_BYTE bits; stuffed bits
// (stuff_hold) consume a bit period without advancing the bit count.
//
// Optional feature macro: TX_BYTE_COUNT_EN adds a saturating byte_count
// output that increments on every byte_done.
module tx_bit_timer #(
    parameter int CYCLES_PER_GROUP = 25,
    parameter int BITS_PER_GROUP   = 3,
    parameter int BITS_PER_BYTE    = 8,
    parameter int BYTE_CNT_W       = 8
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                enable,
    input  logic                                clear,
    input  logic                                stuff_hold,
    output logic                                bit_strobe,
    output logic                                byte_done,
    output logic [$clog2(BITS_PER_BYTE)-1:0]    bit_index,
    output logic [$clog2(CYCLES_PER_GROUP)-1:0] phase
`ifdef TX_BYTE_COUNT_EN
    ,
    output logic [BYTE_CNT_W-1:0]               byte_count
`endif
);

    localparam int PH_W = $clog2(CYCLES_PER_GROUP);
    localparam int BI_W = $clog2(BITS_PER_BYTE);
    localparam int PI_W = (BITS_PER_GROUP > 1) ? $clog2(BITS_PER_GROUP) : 1;
    localparam int PT_N = 2 ** PI_W;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYCLES_PER_GROUP - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(BITS_PER_BYTE - 1);
    localparam logic [PI_W-1:0] PI_LAST = PI_W'(BITS_PER_GROUP - 1);

    // Refuse to elaborate with a parameter set the timing scheme cannot honour.
    if (CYCLES_PER_GROUP < 2 || BITS_PER_GROUP < 1 ||
        BITS_PER_GROUP > CYCLES_PER_GROUP || BITS_PER_BYTE < 2 ||
        BYTE_CNT_W < 1) begin : g_param_check
        $error("tx_bit_timer: illegal parameter combination");
    end

    // Phase value at which strobe k (1-based) of a group fires. Only ever
    // evaluated with elaboration constants, so no divider is built.
    function automatic logic [PH_W-1:0] strobe_pos(input int k);
        return PH_W'((k * CYCLES_PER_GROUP) / BITS_PER_GROUP - 1);
    endfunction

    // Constant lookup of strobe positions, indexed by the group position.
    // Entries beyond BITS_PER_GROUP are unreachable and filled with the
    // group's last phase so the table is fully defined.
    logic [PH_W-1:0] pos_tbl [PT_N];

    for (genvar k = 0; k < PT_N; k++) begin : g_pos
        if (k < BITS_PER_GROUP) begin : g_live
            assign pos_tbl[k] = strobe_pos(k + 1);
        end else begin : g_pad
            assign pos_tbl[k] = PH_LAST;
        end
    end

    logic [PI_W-1:0] grp_idx;
    logic [PI_W-1:0] grp_idx_nxt;
    logic [PH_W-1:0] phase_nxt;
    logic [BI_W-1:0] bit_index_nxt;
    logic            strobe_nxt;
    logic            done_nxt;
    logic            hit;

    // A strobe is due when the phase reaches the current group position.
    assign hit = (phase == pos_tbl[grp_idx]);

    // Next-state decode: clear wins over enable; outputs are one-cycle pulses.
    always_comb begin
        phase_nxt     = phase;
        grp_idx_nxt   = grp_idx;
        bit_index_nxt = bit_index;
        strobe_nxt    = 1'b0;
        done_nxt      = 1'b0;
        if (clear) begin
            phase_nxt     = '0;
            grp_idx_nxt   = '0;
            bit_index_nxt = '0;
        end else if (enable) begin
            phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
            if (hit) begin
                strobe_nxt  = 1'b1;
                grp_idx_nxt = (grp_idx == PI_LAST) ? '0 : grp_idx + 1'b1;
                // A stuffed bit occupies the slot but is not a data bit.
                if (!stuff_hold) begin
                    if (bit_index == BI_LAST) begin
                        bit_index_nxt = '0;
                        done_nxt      = 1'b1;
                    end else begin
                        bit_index_nxt = bit_index + 1'b1;
                    end
                end
            end
        end
    end

    // State and registered output pulses; reset abandons any partial byte.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase      <= '0;
            grp_idx    <= '0;
            bit_index  <= '0;
            bit_strobe <= 1'b0;
            byte_done  <= 1'b0;
        end else begin
            phase      <= phase_nxt;
            grp_idx    <= grp_idx_nxt;
            bit_index  <= bit_index_nxt;
            bit_strobe <= strobe_nxt;
            byte_done  <= done_nxt;
        end
    end

`ifdef TX_BYTE_COUNT_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Completed-byte counter, updated together with the byte_done pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_count <= '0;
        end else if (clear) begin
            byte_count <= '0;
        end else if (done_nxt) begin
            byte_count <= sat_inc(byte_count);
        end
    end
`endif

endmodule
